mips_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair. It is the successor to the single-cycle core's multiply path. The core's controller issues MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO traffic to it. The unit computes iteratively with a start/busy/done handshake, so the datapath can stall on `busy` instead of needing a combinational multiplier. A debug read port matches the core's display-select scheme.

---
 rtl/mips_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
// Flow: IDLE -> PREP (magnitudes, signs) -> RUN (one bit per clock) -> FIX
// (sign correction, HI/LO write, done pulse).
// Optional build macro MIPS_MULDIV_EARLY_TERM_EN: a multiply leaves RUN as
// soon as the remaining multiplier bits are all zero.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_dat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_RUN  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [1:0]         r_op;       // op[1]: divide, op[0]: signed
    logic [WIDTH-1:0]   r_x;        // multiplicand (magnitude after PREP)
    logic [WIDTH-1:0]   r_y;        // multiplier (shifting) or divisor
    logic [WIDTH-1:0]   r_a_org;    // dividend as issued, for divide-by-zero
    logic [WIDTH-1:0]   r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0]   r_q;        // product low half / dividend->quotient
    logic               r_neg_q;
    logic               r_neg_r;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [WIDTH-1:0]   r_opcnt;

    logic [WIDTH-1:0]   w_x_mag;
    logic [WIDTH-1:0]   w_y_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_mul_early;
    logic               w_run_exit;

    assign w_x_mag  = (r_op[0] && r_x[WIDTH-1]) ? -r_x : r_x;
    assign w_y_mag  = (r_op[0] && r_y[WIDTH-1]) ? -r_y : r_y;

    // Shift-add step: add multiplicand when the current multiplier LSB is set,
    // then shift the {acc, q} pair right by one.
    assign w_sum    = {1'b0, r_acc} + (r_y[0] ? {1'b0, r_x} : '0);

    // Restoring-division step: shift next dividend bit into the remainder and
    // subtract the divisor if it fits. The difference is always < divisor, so
    // the low WIDTH bits of the wrap-around subtraction are exact.
    assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_y});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_y;

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    // On early exit r_cnt is left holding the number of skipped iterations,
    // which is exactly how far the product still has to be shifted down.
    assign w_mul_early = !r_op[1] && (r_y[WIDTH-1:1] == '0);
    assign w_prod      = {r_acc, r_q} >> r_cnt;
`else
    assign w_mul_early = 1'b0;
    assign w_prod      = {r_acc, r_q};
`endif

    assign w_run_exit = (r_cnt == '0) || w_mul_early;
    assign w_prod_s   = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_PREP;
            S_PREP: w_next = S_RUN;
            S_RUN:  if (w_run_exit) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath, HI/LO, done pulse and operation counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_a_org <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_opcnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_op    <= op;
                        r_x     <= a;
                        r_y     <= b;
                        r_a_org <= a;
                    end
                end
                S_PREP: begin
                    r_x     <= w_x_mag;
                    r_y     <= w_y_mag;
                    r_neg_q <= r_op[0] & (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
                    r_neg_r <= r_op[0] & r_x[WIDTH-1];
                    r_acc   <= '0;
                    r_q     <= r_op[1] ? w_x_mag : '0;
                    r_cnt   <= CNT_W'(WIDTH - 1);
                end
                S_RUN: begin
                    if (!r_op[1]) begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        r_y   <= r_y >> 1;
                    end else if (w_ge) begin
                        r_acc <= w_sub;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_rem_sh[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    if (!w_run_exit) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod_s;
                    end else if (r_y == '0) begin
                        r_hi <= r_a_org;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_opcnt <= r_opcnt + WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Debug readout mux.
    always_comb begin
        dbg_dat = '0;
        unique case (dbg_sel)
            2'b00: dbg_dat = r_hi;
            2'b01: dbg_dat = r_lo;
            2'b10: dbg_dat = WIDTH'({r_state, r_cnt});
            2'b11: dbg_dat = r_opcnt;
            default: dbg_dat = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: transaction-level reference model (64-bit
// arithmetic plus a cycles-to-done counter) compared every cycle, plus
// directed literal checks. Honors MIPS_MULDIV_EARLY_TERM_EN for latency.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_sel = '0;
    logic [W-1:0] dbg_dat;

    mips_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .dbg_sel(dbg_sel), .dbg_dat(dbg_dat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {hi, lo} result of one operation, from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin u = {32'b0, x} * {32'b0, y}; return u; end
            2'd1: begin p = sx * sy; return p; end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Edges from the start edge to the edge that writes HI/LO.
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MIPS_MULDIV_EARLY_TERM_EN
        logic [31:0] m;
        int k;
        if (o[1]) return W + 2;
        m = (o[0] && y[31]) ? -y : y;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return k + 2;
`else
        return (o == 2'b00) ? W + 2 : W + 2;
`endif
    endfunction

    // Reference model state.
    int          m_rem;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo, m_cnt;
    logic        m_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rem  <= 0;
            m_res  <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
                if (start) begin
                    m_res <= ref_res(op, a, b);
                    m_rem <= ref_lat(op, b);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                    m_cnt  <= m_cnt + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("busy", busy, m_rem != 0);
        chk("done", done, m_done);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        case (dbg_sel)
            2'b00: chk("dbg_hi", dbg_dat, m_hi);
            2'b01: chk("dbg_lo", dbg_dat, m_lo);
            2'b11: chk("dbg_opcnt", dbg_dat, m_cnt);
            default: ;
        endcase
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op (caller is at a negedge). noise: 0 none, 1 fixed ignored
    // start+MTLO mid-run, 2 random traffic while busy. Returns at a negedge
    // right after done, with all strobes cleared.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic hw, input logic lw, input int noise,
                         output int nbusy, output int lat);
        bit got;
        op = o; a = x; b = y; start = 1'b1;
        hi_we = hw; lo_we = lw; wdata = $urandom;
        dbg_sel = 2'($urandom_range(0, 3));
        got = 0; nbusy = 0; lat = 0;
        @(posedge clk); #1;
        while (lat < 100) begin
            if (busy) nbusy++;
            if (done) begin got = 1; break; end
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            a = $urandom; b = $urandom;
            dbg_sel = 2'($urandom_range(0, 3));
            if (noise == 1 && lat == 5) begin
                start = 1'b1; op = 2'b00; a = 1; b = 1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else if (noise == 2 && $urandom_range(0, 3) == 0) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        int nb, lt, ops;
        logic [1:0] ro;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);

        do_op(2'b00, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, nb, lt);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
`ifdef MIPS_MULDIV_EARLY_TERM_EN
        chk("multu_lat", lt, 4);
        chk("multu_busy_cycles", nb, 4);
`else
        chk("multu_lat", lt, 34);
        chk("multu_busy_cycles", nb, 34);
`endif
        do_op(2'b01, 32'hFFFF_FFFD, 32'h5, 0, 0, 0, nb, lt);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        do_op(2'b11, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, nb, lt);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lat", lt, 34);
        do_op(2'b10, 32'd100, 32'h0, 0, 0, 0, nb, lt);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h64);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, nb, lt);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", hi, 32'h1234);
        do_op(2'b00, 32'd6, 32'd7, 0, 0, 1, nb, lt);
        chk("ignore_hi", hi, 32'h0);
        chk("ignore_lo", lo, 32'd42);

        // Abort a divide with reset after its tenth edge.
        op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ops = 0;
        do_op(2'b00, 32'd2, 32'd3, 0, 0, 0, nb, lt);
        ops++;
        chk("post_rst_lo", lo, 32'd6);
        do_op(2'b00, 32'd3, 32'd5, 0, 0, 0, nb, lt);
        ops++;
        chk("early_lo", lo, 32'd15);
`ifdef MIPS_MULDIV_EARLY_TERM_EN
        chk("early_lat", lt, 5);
`else
        chk("early_lat", lt, 34);
`endif

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            do_op(ro, rnd_val(), rnd_val(), 1'($urandom), 1'($urandom), 2, nb, lt);
            ops++;
        end

        dbg_sel = 2'b11;
        #1;
        chk("opcount", dbg_dat, ops);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
